// File: rtl/fsm_stim_pkg.sv
// Shared constants for the command-FSM stimulus driver: state encodings,
// neutral input code and counter widths.
// Pure declarations; no logic, no latency, no flow control.
package fsm_stim_pkg;

    // 3-bit state register; encodings 4..7 are illegal and recover to IDLE
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_RESP    = 3'd3
    } state_e;

    // Code driven onto the FSM input whenever no command is active
    localparam int NEUTRAL_CODE = 0;

    // Settle counter covers SETTLE 0..15, timeout counter covers 1..255
    localparam int SETTLE_CNT_W = 4;
    localparam int TO_CNT_W     = 8;

    // True for the four defined state encodings
    function automatic logic is_legal_state(input logic [STATE_W-1:0] s);
        return (s <= 3'd3);
    endfunction

endpackage

// File: rtl/fsm_stim_dncnt.sv
// Loadable down-counter with zero flag; load has priority over decrement.
// Zero flag is combinational from the registered count; load/decrement take one cycle.
// No flow control; decrement is ignored once the count has reached zero.
module fsm_stim_dncnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Count register: reset to 0, load wins, otherwise saturating decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fsm_stim_driver.sv
// Drives each accepted command onto the FSM input, samples fsm_out and returns it with the command.
// Latency: accept at cycle 0, sample at end of cycle SETTLE+2, rsp_valid in cycle SETTLE+3.
// One command in flight; cmd_ready low while busy, response held until rsp_ready (FSM_STIM_RSP_TIMEOUT_EN adds a drop timeout).
module fsm_stim_driver
    import fsm_stim_pkg::*;
#(
    parameter int DATA_W  = 3,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] rsp_cmd,
    output logic [DATA_W-1:0] fsm_user_input,
    input  logic [DATA_W-1:0] fsm_out,
    output logic              busy,
    output logic              err_illegal,
    output logic              err_timeout
);

    // Elaboration-time guard on parameter ranges
    if (SETTLE < 0 || SETTLE > 15) begin : g_bad_settle
        $error("fsm_stim_driver: SETTLE must be within 0..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fsm_stim_driver: TIMEOUT must be within 1..255");
    end

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LD = SETTLE_CNT_W'(SETTLE);
    localparam logic [DATA_W-1:0]       NEUTRAL   = DATA_W'(NEUTRAL_CODE);

    logic [STATE_W-1:0] state_q, state_d;
    logic               illegal;
    logic               accept;
    logic               rsp_hs;
    logic               timeout_fire;
    logic               settle_zero;

    logic [DATA_W-1:0]  cmd_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic [DATA_W-1:0]  rsp_cmd_q;
    logic [DATA_W-1:0]  fui_q;
    logic               rsp_valid_q;
    logic               err_illegal_q;

    assign accept = cmd_valid && cmd_ready;
    assign rsp_hs = (state_q == ST_RESP) && rsp_valid_q && rsp_ready;

    // Settle window: loaded on acceptance, counts down while in SETTLE
    fsm_stim_dncnt #(
        .W (SETTLE_CNT_W)
    ) u_settle_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (SETTLE_LD),
        .en_i       (state_q == ST_SETTLE),
        .zero_o     (settle_zero)
    );

`ifdef FSM_STIM_RSP_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TIMEOUT_LD = TO_CNT_W'(TIMEOUT - 1);

    logic to_zero;
    logic err_timeout_q;

    // Response wait budget: loaded while entering RESP, counts cycles without rsp_ready
    fsm_stim_dncnt #(
        .W (TO_CNT_W)
    ) u_timeout_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == ST_CAPTURE),
        .load_val_i (TIMEOUT_LD),
        .en_i       ((state_q == ST_RESP) && !rsp_ready),
        .zero_o     (to_zero)
    );

    // Expiry only without rsp_ready, so a handshake on the expiry cycle wins
    assign timeout_fire = (state_q == ST_RESP) && to_zero && !rsp_ready;

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout_q <= 1'b0;
        end else if (timeout_fire) begin
            err_timeout_q <= 1'b1;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign timeout_fire = 1'b0;
    assign err_timeout  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; every undefined encoding returns to IDLE and is flagged
    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_zero) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_hs || timeout_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                illegal = !is_legal_state(state_q);
            end
        endcase
    end

    // Output decode: only cmd_ready and busy come straight from the state
    always_comb begin
        cmd_ready = (state_q == ST_IDLE) && !rst;
        busy      = (state_q != ST_IDLE);
    end

    // Registered datapath: command latch, FSM drive, response capture, error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q         <= '0;
            fui_q         <= NEUTRAL;
            rsp_data_q    <= '0;
            rsp_cmd_q     <= '0;
            rsp_valid_q   <= 1'b0;
            err_illegal_q <= 1'b0;
        end else if (illegal) begin
            fui_q         <= NEUTRAL;
            rsp_valid_q   <= 1'b0;
            err_illegal_q <= 1'b1;
        end else begin
            if (accept) begin
                cmd_q <= cmd_data;
                fui_q <= cmd_data;
            end
            if (state_q == ST_CAPTURE) begin
                rsp_data_q  <= fsm_out;
                rsp_cmd_q   <= cmd_q;
                rsp_valid_q <= 1'b1;
                fui_q       <= NEUTRAL;
            end
            if (rsp_hs || timeout_fire) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_cmd        = rsp_cmd_q;
    assign fsm_user_input = fui_q;
    assign err_illegal    = err_illegal_q;

endmodule

// File: tb/tb_fsm_stim_driver.sv
// Directed bench for fsm_stim_driver: one instance with SETTLE=2, one with SETTLE=0 / TIMEOUT=4.
// The FSM is modelled as a rotate-left of its input; expected values are hand-computed constants.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fsm_stim_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy, err_illegal, err_timeout;
    logic [2:0] cmd_data, rsp_data, rsp_cmd, fui, fsm_out;

    logic       cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b, busy_b, err_illegal_b, err_timeout_b;
    logic [2:0] cmd_data_b, rsp_data_b, rsp_cmd_b, fui_b, fsm_out_b;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [2:0] fsm_model(input logic [2:0] x);
        return {x[1:0], x[2]};
    endfunction

    assign fsm_out   = fsm_model(fui);
    assign fsm_out_b = fsm_model(fui_b);

    fsm_stim_driver #(.DATA_W(3), .SETTLE(2), .TIMEOUT(64)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_cmd(rsp_cmd),
        .fsm_user_input(fui), .fsm_out(fsm_out),
        .busy(busy), .err_illegal(err_illegal), .err_timeout(err_timeout)
    );

    fsm_stim_driver #(.DATA_W(3), .SETTLE(0), .TIMEOUT(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_data(cmd_data_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_data(rsp_data_b), .rsp_cmd(rsp_cmd_b),
        .fsm_user_input(fui_b), .fsm_out(fsm_out_b),
        .busy(busy_b), .err_illegal(err_illegal_b), .err_timeout(err_timeout_b)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait (bounded) for a response on instance A, check it, then complete the handshake
    task automatic wait_rsp_a(input logic [2:0] exp_cmd, input logic [2:0] exp_dat);
        int n = 0;
        while (!rsp_valid && n < 30) begin
            tick();
            n++;
        end
        chk("rsp_wait", 8'(rsp_valid), 8'd1);
        chk("rsp_cmd", 8'(rsp_cmd), 8'(exp_cmd));
        chk("rsp_data", 8'(rsp_data), 8'(exp_dat));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("idle_after_hs", 8'(busy), 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [2:0] exp_q[$];
        logic [2:0] e;
        int         n_rsp;
        int         last;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b0;
        cmd_valid_b = 1'b0; cmd_data_b = '0; rsp_ready_b = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_cmd_ready", 8'(cmd_ready), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("rst_fui", 8'(fui), 8'd0);
        chk("rst_err_illegal", 8'(err_illegal), 8'd0);
        chk("rst_err_timeout", 8'(err_timeout), 8'd0);
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", 8'(cmd_ready), 8'd1);

        // Single command 101, SETTLE=2
        cmd_valid = 1'b1; cmd_data = 3'b101;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("single_fui", 8'(fui), 8'h5);
            chk("single_no_rsp", 8'(rsp_valid), 8'd0);
            chk("single_busy_rdy", 8'({busy, cmd_ready}), 8'h2);
            tick();
        end
        chk("single_rsp_valid", 8'(rsp_valid), 8'd1);
        chk("single_rsp_data", 8'(rsp_data), 8'h3);
        chk("single_rsp_cmd", 8'(rsp_cmd), 8'h5);
        chk("single_fui_neutral", 8'(fui), 8'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("single_idle", 8'({busy, rsp_valid, cmd_ready}), 8'h1);

        // Backpressure with a command held pending
        cmd_valid = 1'b1; cmd_data = 3'b010;
        repeat (5) tick();
        chk("bp_rsp_rise", 8'(rsp_valid), 8'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", 8'(rsp_valid), 8'd1);
            chk("bp_rsp_data", 8'(rsp_data), 8'h4);
            chk("bp_rsp_cmd", 8'(rsp_cmd), 8'h2);
            chk("bp_cmd_ready", 8'(cmd_ready), 8'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_idle_rdy", 8'({cmd_ready, rsp_valid}), 8'h2);
        tick();
        chk("bp_second_accept", 8'({busy, fui}), 8'hA);
        cmd_valid = 1'b0;
        wait_rsp_a(3'b010, 3'b100);

        // Reset in cycle 2 of a transaction
        cmd_valid = 1'b1; cmd_data = 3'b110;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 8'(busy), 8'd0);
        chk("mid_rst_fui", 8'(fui), 8'd0);
        chk("mid_rst_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("mid_rst_rsp_data", 8'(rsp_data), 8'd0);
        chk("mid_rst_rsp_cmd", 8'(rsp_cmd), 8'd0);
        chk("mid_rst_cmd_ready", 8'(cmd_ready), 8'd0);
        rst = 1'b0;
        cmd_valid = 1'b1; cmd_data = 3'b001;
        #1;
        chk("post_rst_ready", 8'(cmd_ready), 8'd1);
        tick();
        cmd_valid = 1'b0;
        chk("post_rst_accept", 8'({busy, fui}), 8'h9);
        wait_rsp_a(3'b001, 3'b010);

        // Illegal state encoding injected during SETTLE
        cmd_valid = 1'b1; cmd_data = 3'b011;
        tick();
        cmd_valid = 1'b0;
        chk("ill_pre_fui", 8'(fui), 8'h3);
        force u_dut.state_q = 3'd6;
        tick();
        release u_dut.state_q;
        tick();
        chk("ill_busy", 8'(busy), 8'd0);
        chk("ill_err", 8'(err_illegal), 8'd1);
        chk("ill_fui", 8'(fui), 8'd0);
        chk("ill_rsp_valid", 8'(rsp_valid), 8'd0);
        cmd_valid = 1'b1; cmd_data = 3'b100;
        tick();
        cmd_valid = 1'b0;
        wait_rsp_a(3'b100, 3'b001);
        chk("ill_sticky", 8'(err_illegal), 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ill_cleared", 8'(err_illegal), 8'd0);

        // SETTLE=0 instance: single command 111
        cmd_valid_b = 1'b1; cmd_data_b = 3'b111;
        tick();
        cmd_valid_b = 1'b0;
        chk("s0_c1", 8'({rsp_valid_b, fui_b}), 8'h7);
        tick();
        chk("s0_c2", 8'({rsp_valid_b, fui_b}), 8'h7);
        tick();
        chk("s0_rsp_valid", 8'(rsp_valid_b), 8'd1);
        chk("s0_rsp_data", 8'(rsp_data_b), 8'h7);
        chk("s0_rsp_cmd", 8'(rsp_cmd_b), 8'h7);
        chk("s0_fui_neutral", 8'(fui_b), 8'd0);
        rsp_ready_b = 1'b1;
        tick();
        chk("s0_idle", 8'(busy_b), 8'd0);

        // SETTLE=0 back-to-back: one response every 4 cycles
        cmd_valid_b = 1'b1;
        n_rsp = 0;
        last = -1;
        for (int i = 0; i < 16; i++) begin
            if (rsp_valid_b) begin
                n_rsp++;
                chk("b2b_spacing", 8'(i - last), (last < 0) ? 8'd4 : 8'd4);
                last = i;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("b2b_cmd", 8'(rsp_cmd_b), 8'(e));
                    chk("b2b_data", 8'(rsp_data_b), 8'(fsm_model(e)));
                end else begin
                    chk("b2b_unexpected_rsp", 8'(rsp_valid_b), 8'd0);
                end
            end
            cmd_data_b = 3'(i + 1);
            if (cmd_ready_b) exp_q.push_back(cmd_data_b);
            tick();
        end
        cmd_valid_b = 1'b0;
        rsp_ready_b = 1'b0;
        chk("b2b_count", 8'(n_rsp), 8'd4);
        chk("b2b_queue_empty", 8'(exp_q.size()), 8'd0);
        chk("b2b_idle", 8'(busy_b), 8'd0);

`ifdef FSM_STIM_RSP_TIMEOUT_EN
        // TIMEOUT=4 with rsp_ready held low
        cmd_valid_b = 1'b1; cmd_data_b = 3'b110;
        tick();
        cmd_valid_b = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 4; k++) begin
            chk("to_rsp_held", 8'(rsp_valid_b), 8'd1);
            tick();
        end
        chk("to_dropped", 8'(rsp_valid_b), 8'd0);
        chk("to_err", 8'(err_timeout_b), 8'd1);
        chk("to_idle", 8'(busy_b), 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("to_err_cleared", 8'(err_timeout_b), 8'd0);

        // Handshake on the expiry cycle wins
        cmd_valid_b = 1'b1; cmd_data_b = 3'b011;
        tick();
        cmd_valid_b = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            chk("to2_rsp_held", 8'(rsp_valid_b), 8'd1);
            tick();
        end
        chk("to2_expiry_valid", 8'(rsp_valid_b), 8'd1);
        chk("to2_rsp_data", 8'(rsp_data_b), 8'h6);
        rsp_ready_b = 1'b1;
        tick();
        rsp_ready_b = 1'b0;
        chk("to2_delivered", 8'({busy_b, rsp_valid_b}), 8'd0);
        chk("to2_no_err", 8'(err_timeout_b), 8'd0);
`else
        chk("no_to_err_a", 8'(err_timeout), 8'd0);
        chk("no_to_err_b", 8'(err_timeout_b), 8'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fsm_stim_driver.md
Name: fsm_stim_driver

Overview:
- Host-side counterpart of the 3-bit command FSM. It accepts commands over a valid/ready stream and drives each code onto the FSM's user_input for a fixed settle window.
- It samples the FSM's out value and returns it with the originating command over a valid/ready response stream.
- It sits between the test/host fabric and the FSM.
- Hardened state machine: every unused encoding recovers to IDLE and is flagged.

Parameters:
- DATA_W, 3: width of command code, FSM input and FSM output.
- SETTLE, 2: extra cycles user_input is held before sampling. Legal range 0..15.
- TIMEOUT, 16: response-wait limit in cycles. Used only with the optional feature. Legal range 1..255.

Ports:
- clk  in  1  sole clock; all logic updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept a command.
- cmd_data  in  DATA_W  command code.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_W  sampled FSM output.
- rsp_cmd  out  DATA_W  command that produced rsp_data.
- fsm_user_input  out  DATA_W  drive to the FSM input.
- fsm_out  in  DATA_W  FSM output.
- busy  out  1  high whenever state is not IDLE.
- err_illegal  out  1  sticky: illegal state encoding was detected.
- err_timeout  out  1  sticky: response was dropped on timeout (tied 0 without the feature).

Behaviour:
- Reset: synchronous; rst sampled high has priority over every other event.
  - Next state is IDLE.
  - rsp_valid, rsp_data, rsp_cmd, fsm_user_input, counter, err_illegal and err_timeout all go to 0.
  - cmd_ready is 0 while rst is high.
  - A reset mid-operation aborts the transaction; no response is emitted.
- State register: 3 bits. IDLE=0, SETTLE=1, CAPTURE=2, RESP=3. Encodings 4..7 are illegal.
- IDLE:
  - cmd_ready = 1 (combinational from state, gated by !rst).
  - On cmd_valid & cmd_ready: cmd_q <= cmd_data, fsm_user_input <= cmd_data, cnt <= SETTLE, next state SETTLE.
- SETTLE:
  - If cnt == 0, go to CAPTURE; otherwise cnt <= cnt-1.
  - The state therefore lasts SETTLE+1 cycles.
- CAPTURE (one cycle):
  - rsp_data <= fsm_out, rsp_cmd <= cmd_q, rsp_valid <= 1.
  - fsm_user_input <= 0 (neutral code).
  - Next state RESP.
- RESP:
  - Hold rsp_* stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid <= 0, next state IDLE.
  - The next command is accepted no earlier than the cycle after.
- Timing (acceptance at cycle 0):
  - fsm_user_input equals the command in cycles 1..SETTLE+2.
  - fsm_out is sampled at the end of cycle SETTLE+2.
  - rsp_valid rises in cycle SETTLE+3.
  - Throughput is at most one command per SETTLE+4 cycles.
- Commands presented while busy are not accepted; cmd_ready stays 0 and the source must hold its data.
- rsp_ready asserted while rsp_valid is 0 has no effect.
- Illegal encoding (any cause, e.g. fault injection):
  - Next state IDLE, fsm_user_input <= 0, rsp_valid <= 0.
  - err_illegal <= 1 and stays set until rst.
- Counter width is 4 bits. No wrap is possible: the counter only decrements from SETTLE and stops at 0.
- All outputs are registered except cmd_ready and busy, which are decoded from state.

Optional Feature:
- Macro: FSM_STIM_RSP_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter is loaded with TIMEOUT-1 on entry to RESP and decrements each cycle rsp_ready is low.
  - If it reaches 0 without a handshake: rsp_valid <= 0, err_timeout <= 1 (sticky), next state IDLE.
  - A handshake in the same cycle as expiry wins: the response is delivered and no error is raised.
- Not defined:
  - RESP waits indefinitely.
  - err_timeout is tied to 0 and no wait-counter logic is present.

Decomposition:
- Package fsm_stim_pkg holds:
  - state width (3) and the four state encodings;
  - neutral input code (0);
  - settle-counter width (4) and timeout-counter width (8).
- One sub-module, fsm_stim_dncnt: loadable down-counter with load, enable and zero flag, parameterised on width.
  - Instantiated for the settle counter.
  - Instantiated for the timeout counter only under the macro.

Test Plan:
- Single command: SETTLE=2, cmd_data=3'b101 accepted at cycle 0, fsm_out model returns 3'b011 → fsm_user_input=101 in cycles 1..4 and 000 afterwards; rsp_valid rises at cycle 5 with rsp_data=011, rsp_cmd=101; busy is low again after the handshake.
- Backpressure: rsp_ready held low 10 cycles with cmd_valid held high and cmd_data=3'b010 → rsp_* stable, cmd_ready=0 throughout; the second command is accepted the cycle after the rsp handshake.
- Reset mid-operation: rst pulsed at cycle 2 of a transaction → next cycle state IDLE, all outputs 0, no rsp_valid pulse, a new command is accepted immediately after rst falls.
- Illegal state: force state_reg=3'd6 → next cycle IDLE, err_illegal=1, fsm_user_input=0; err_illegal persists through later commands until rst.
- SETTLE=0 corner: command 3'b111 at cycle 0 → sampled end of cycle 2, rsp_valid at cycle 3; back-to-back commands with rsp_ready=1 give one response per 4 cycles.
- With FSM_STIM_RSP_TIMEOUT_EN and TIMEOUT=4: rsp_ready held low → rsp_valid drops after 4 RESP cycles, err_timeout=1, state IDLE; rsp_ready raised exactly on the expiry cycle → response delivered, err_timeout stays 0.
